// File: rtl/flow_ctrl_pkg.sv
// Shared encodings for the rx flow-control storm limiter: frame classes,
// decision FSM states and default datapath widths.
`timescale 1ns/1ps
package flow_ctrl_pkg;

    localparam int LEN_W_DEF      = 16;
    localparam int ACC_W_DEF      = 32;
    localparam int DROP_CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        CLS_UC  = 2'b00,
        CLS_MC  = 2'b01,
        CLS_BC  = 2'b10,
        CLS_RSV = 2'b11
    } frm_class_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_OUT   = 2'b10
    } state_t;

endpackage

// File: rtl/storm_class_acc.sv
// One traffic class of the storm limiter: per-second byte accumulator,
// budget compare, drop counter and snapshot of the last closed window.
`timescale 1ns/1ps
module storm_class_acc
    import flow_ctrl_pkg::*;
#(
    parameter int LEN_W      = LEN_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int DROP_CNT_W = DROP_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hit,
    input  logic                  check,
    input  logic [LEN_W-1:0]      len,
    input  logic [ACC_W-1:0]      limit,
    input  logic                  tick,
    output logic                  pass,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [ACC_W-1:0]      last_bytes
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   base_ext;
    logic [ACC_W:0]   len_ext;
    logic [ACC_W:0]   sum;

    // A tick in the same cycle as the check opens a fresh window, so the
    // frame is judged against an empty accumulator. One extra bit keeps
    // acc + len from wrapping before the compare.
    assign base_ext = tick ? '0 : {1'b0, acc};
    assign len_ext  = {{(ACC_W + 1 - LEN_W){1'b0}}, len};
    assign sum      = base_ext + len_ext;
    assign pass     = (sum <= {1'b0, limit});

    // NOTE: state registers use non-blocking assignments so the tick clear
    // and the later pass update resolve as last-assignment-wins in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            drop_cnt   <= '0;
            last_bytes <= '0;
        end else begin
            if (tick) begin
                last_bytes <= acc;
                acc        <= '0;
            end
            if (check && hit) begin
                if (pass) begin
                    acc <= sum[ACC_W-1:0];
                end else begin
                    drop_cnt <= drop_cnt + DROP_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/storm_ctrl_limiter.sv
// Per-port broadcast/multicast storm limiter: one forward/drop decision per
// frame descriptor against per-second byte budgets, windows closed by pps.
`timescale 1ns/1ps
module storm_ctrl_limiter
    import flow_ctrl_pkg::*;
#(
    parameter int LEN_W      = LEN_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int DROP_CNT_W = DROP_CNT_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_pps_valid,
    output logic                  o_pps_ready,
    input  logic                  i_frm_valid,
    output logic                  o_frm_ready,
    input  logic [LEN_W-1:0]      i_frm_len,
    input  logic [1:0]            i_frm_class,
    output logic                  o_dec_valid,
    input  logic                  i_dec_ready,
    output logic                  o_dec_pass,
    input  logic                  i_limit_en,
    input  logic [ACC_W-1:0]      i_bc_limit,
    input  logic [ACC_W-1:0]      i_mc_limit,
    output logic [DROP_CNT_W-1:0] o_bc_drop_cnt,
    output logic [DROP_CNT_W-1:0] o_mc_drop_cnt,
    output logic [ACC_W-1:0]      o_bc_last_bytes,
    output logic [ACC_W-1:0]      o_mc_last_bytes
);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    frm_class_t       cls_q;
    logic             tick;
    logic             check;
    logic             bc_hit;
    logic             mc_hit;
    logic             bc_pass;
    logic             mc_pass;

    // The tick source holds valid until accepted and is never back-pressured.
    assign o_pps_ready = i_pps_valid;
    assign tick        = i_pps_valid && o_pps_ready;

    assign check  = (state == ST_CHECK);
    assign bc_hit = i_limit_en && (cls_q == CLS_BC);
    assign mc_hit = i_limit_en && (cls_q == CLS_MC);

    storm_class_acc #(
        .LEN_W      (LEN_W),
        .ACC_W      (ACC_W),
        .DROP_CNT_W (DROP_CNT_W)
    ) u_bc_acc (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .hit        (bc_hit),
        .check      (check),
        .len        (len_q),
        .limit      (i_bc_limit),
        .tick       (tick),
        .pass       (bc_pass),
        .drop_cnt   (o_bc_drop_cnt),
        .last_bytes (o_bc_last_bytes)
    );

    storm_class_acc #(
        .LEN_W      (LEN_W),
        .ACC_W      (ACC_W),
        .DROP_CNT_W (DROP_CNT_W)
    ) u_mc_acc (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .hit        (mc_hit),
        .check      (check),
        .len        (len_q),
        .limit      (i_mc_limit),
        .tick       (tick),
        .pass       (mc_pass),
        .drop_cnt   (o_mc_drop_cnt),
        .last_bytes (o_mc_last_bytes)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            cls_q       <= CLS_UC;
            o_frm_ready <= 1'b1;
            o_dec_valid <= 1'b0;
            o_dec_pass  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_frm_valid) begin
                        len_q       <= i_frm_len;
                        cls_q       <= frm_class_t'(i_frm_class);
                        o_frm_ready <= 1'b0;
                        state       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // Unicast, reserved and limiter-disabled frames always pass.
                    o_dec_valid <= 1'b1;
                    o_dec_pass  <= bc_hit ? bc_pass :
                                   mc_hit ? mc_pass : 1'b1;
                    state       <= ST_OUT;
                end
                ST_OUT: begin
                    if (i_dec_ready) begin
                        o_dec_valid <= 1'b0;
                        o_dec_pass  <= 1'b0;
                        o_frm_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    o_dec_valid <= 1'b0;
                    o_dec_pass  <= 1'b0;
                    o_frm_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_storm_ctrl_limiter.sv
// Directed self-checking bench for storm_ctrl_limiter: window accounting,
// tick/check collision, limit changes, back-pressure and async reset.
`timescale 1ns/1ps
module tb_storm_ctrl_limiter;

    logic        clk;
    logic        rst_n;
    logic        pps_valid;
    logic        pps_ready;
    logic        frm_valid;
    logic        frm_ready;
    logic [15:0] frm_len;
    logic [1:0]  frm_class;
    logic        dec_valid;
    logic        dec_ready;
    logic        dec_pass;
    logic        limit_en;
    logic [31:0] bc_limit;
    logic [31:0] mc_limit;
    logic [31:0] bc_drop_cnt;
    logic [31:0] mc_drop_cnt;
    logic [31:0] bc_last_bytes;
    logic [31:0] mc_last_bytes;

    int checks = 0;
    int errors = 0;

    storm_ctrl_limiter dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_pps_valid     (pps_valid),
        .o_pps_ready     (pps_ready),
        .i_frm_valid     (frm_valid),
        .o_frm_ready     (frm_ready),
        .i_frm_len       (frm_len),
        .i_frm_class     (frm_class),
        .o_dec_valid     (dec_valid),
        .i_dec_ready     (dec_ready),
        .o_dec_pass      (dec_pass),
        .i_limit_en      (limit_en),
        .i_bc_limit      (bc_limit),
        .i_mc_limit      (mc_limit),
        .o_bc_drop_cnt   (bc_drop_cnt),
        .o_mc_drop_cnt   (mc_drop_cnt),
        .o_bc_last_bytes (bc_last_bytes),
        .o_mc_last_bytes (mc_last_bytes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Present one descriptor, optionally tick during CHECK, check the
    // 2-cycle latency and the decision, then accept it.
    task automatic send_frame(input logic [15:0] len, input logic [1:0] cls,
                              input logic tick_in_check, input logic exp_pass,
                              input string name);
        @(negedge clk);
        checks++;
        if (frm_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s frm_ready: got %b expected 1", name, frm_ready);
        end
        frm_valid = 1'b1;
        frm_len   = len;
        frm_class = cls;
        @(negedge clk);
        frm_valid = 1'b0;
        checks++;
        if (dec_valid !== 1'b0 || frm_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s check-cycle: dec_valid %b frm_ready %b expected 0 0", name, dec_valid, frm_ready);
        end
        if (tick_in_check) pps_valid = 1'b1;
        @(negedge clk);
        pps_valid = 1'b0;
        checks++;
        if (dec_valid !== 1'b1 || dec_pass !== exp_pass) begin
            errors++;
            $display("FAIL %s decision: valid %b pass %b expected 1 %b", name, dec_valid, dec_pass, exp_pass);
        end
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        checks++;
        if (dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s release: dec_valid %b expected 0", name, dec_valid);
        end
    endtask

    task automatic do_tick(input string name);
        @(negedge clk);
        pps_valid = 1'b1;
        #1;
        checks++;
        if (pps_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s pps_ready: got %b expected 1", name, pps_ready);
        end
        @(negedge clk);
        pps_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        pps_valid = 1'b0;
        frm_valid = 1'b0;
        frm_len   = '0;
        frm_class = 2'b00;
        dec_ready = 1'b0;
        limit_en  = 1'b0;
        bc_limit  = 32'd3000;
        mc_limit  = 32'd0;
        repeat (3) @(negedge clk);
        chk32("reset frm_ready", {31'd0, frm_ready}, 32'd1);
        chk32("reset dec_valid", {31'd0, dec_valid}, 32'd0);
        chk32("reset dec_pass", {31'd0, dec_pass}, 32'd0);
        chk32("reset bc_drop", bc_drop_cnt, 32'd0);
        chk32("reset mc_drop", mc_drop_cnt, 32'd0);
        chk32("reset bc_last", bc_last_bytes, 32'd0);
        chk32("reset mc_last", mc_last_bytes, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_limit_disabled();
        limit_en = 1'b0;
        for (int i = 0; i < 5; i++) send_frame(16'd1000, 2'b10, 1'b0, 1'b1, "dis_bc");
        chk32("dis bc_drop", bc_drop_cnt, 32'd0);
        chk32("dis mc_drop", mc_drop_cnt, 32'd0);
        do_tick("dis_tick");
        chk32("dis bc_last no accumulation", bc_last_bytes, 32'd0);
    endtask

    task automatic test_bc_budget();
        limit_en = 1'b1;
        bc_limit = 32'd3000;
        send_frame(16'd1000, 2'b10, 1'b0, 1'b1, "bud_1000a");
        send_frame(16'd1000, 2'b10, 1'b0, 1'b1, "bud_1000b");
        send_frame(16'd1000, 2'b10, 1'b0, 1'b1, "bud_1000c_exact");
        send_frame(16'd64,   2'b10, 1'b0, 1'b0, "bud_64_over");
        chk32("bud bc_drop", bc_drop_cnt, 32'd1);
        chk32("bud mc_drop", mc_drop_cnt, 32'd0);
    endtask

    task automatic test_window_rollover();
        do_tick("roll_tick");
        chk32("roll bc_last", bc_last_bytes, 32'd3000);
        chk32("roll mc_last", mc_last_bytes, 32'd0);
        send_frame(16'd64,   2'b10, 1'b0, 1'b1, "roll_64");
        // 64 + 2936 fills the window exactly, so one more byte drops.
        send_frame(16'd2936, 2'b10, 1'b0, 1'b1, "roll_fill");
        send_frame(16'd1,    2'b10, 1'b0, 1'b0, "roll_full");
        chk32("roll bc_drop", bc_drop_cnt, 32'd2);
    endtask

    task automatic test_tick_in_check();
        send_frame(16'd500, 2'b10, 1'b1, 1'b1, "coll_500");
        chk32("coll bc_last", bc_last_bytes, 32'd3000);
        bc_limit = 32'd400;
        send_frame(16'd1, 2'b10, 1'b0, 1'b0, "lowered_limit");
        chk32("lowered bc_drop", bc_drop_cnt, 32'd3);
        do_tick("coll_tick");
        chk32("coll acc was 500", bc_last_bytes, 32'd500);
        bc_limit = 32'd3000;
    endtask

    task automatic test_mc_and_unicast();
        mc_limit = 32'd0;
        send_frame(16'd64,   2'b01, 1'b0, 1'b0, "mc_zero_limit");
        chk32("mc drop", mc_drop_cnt, 32'd1);
        send_frame(16'd1518, 2'b00, 1'b0, 1'b1, "uc_1518");
        send_frame(16'd2000, 2'b11, 1'b0, 1'b1, "rsv_2000");
        chk32("uc bc_drop untouched", bc_drop_cnt, 32'd3);
        chk32("uc mc_drop untouched", mc_drop_cnt, 32'd1);
        chk32("uc bc_last untouched", bc_last_bytes, 32'd500);
    endtask

    task automatic test_back_pressure_reset();
        @(negedge clk);
        frm_valid = 1'b1;
        frm_len   = 16'd100;
        frm_class = 2'b10;
        @(negedge clk);
        frm_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (dec_valid !== 1'b1 || dec_pass !== 1'b1 || frm_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: valid %b pass %b frm_ready %b expected 1 1 0",
                         i, dec_valid, dec_pass, frm_ready);
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk32("rst dec_valid", {31'd0, dec_valid}, 32'd0);
        chk32("rst frm_ready", {31'd0, frm_ready}, 32'd1);
        chk32("rst bc_drop", bc_drop_cnt, 32'd0);
        chk32("rst mc_drop", mc_drop_cnt, 32'd0);
        chk32("rst bc_last", bc_last_bytes, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(16'd200, 2'b10, 1'b0, 1'b1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_limit_disabled();
        test_bc_budget();
        test_window_rollover();
        test_tick_in_check();
        test_mc_and_unicast();
        test_back_pressure_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
